// File: rtl/exp_accel_core.sv
// exp_accel_core: Avalon-MM integer power engine, BASE^EXP mod 2^WIDTH.
// Ports: clk_clk, reset_reset_n, avs_* CSR slave, irq (done & irq_en), busy_export.
module exp_accel_core #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        irq,
  output logic        busy_export
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MUL,
    S_SQR,
    S_FINISH
  } state_t;

  state_t state;

  logic [WIDTH-1:0]     base_q;
  logic [WIDTH-1:0]     base_nx;
  logic [WIDTH-1:0]     result_q;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     b;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [EXP_WIDTH-1:0] e;
  logic                 busy;
  logic                 done;
  logic                 ovf;
  logic                 irq_en;

  logic [WIDTH-1:0]   mul_a;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   prod_hi;
  logic [WIDTH-1:0]   prod_lo;

  logic        wr_ctrl;
  logic        wr_base;
  logic        wr_exp;
  logic        wr_status;
  logic        start;
  logic [31:0] base_lo_rd;
  logic [31:0] base_hi_rd;
  logic [31:0] res_lo_rd;
  logic [31:0] res_hi_rd;
  logic [31:0] rd_mux;

  assign wr_ctrl   = avs_write && (avs_address == 3'd0);
  assign wr_base   = avs_write && (avs_address == 3'd1);
  assign wr_exp    = avs_write && (avs_address == 3'd2);
  assign wr_status = avs_write && (avs_address == 3'd4);
  assign start     = wr_ctrl && avs_writedata[0];

  // One multiplier: acc*b in MUL, b*b otherwise.
  assign mul_a   = (state == S_MUL) ? acc : b;
  assign prod    = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, b};
  assign prod_hi = prod[2*WIDTH-1:WIDTH];
  assign prod_lo = prod[WIDTH-1:0];

  // Wide operands split across a low word and a high word.
  generate
    if (WIDTH > 32) begin : g_wide
      always_comb begin
        base_nx = base_q;
        if (wr_base) base_nx[31:0] = avs_writedata;
        if (avs_write && (avs_address == 3'd5))
          base_nx[WIDTH-1:32] = avs_writedata[WIDTH-33:0];
      end
      assign base_lo_rd = base_q[31:0];
      assign res_lo_rd  = result_q[31:0];
      assign base_hi_rd = 32'(base_q[WIDTH-1:32]);
      assign res_hi_rd  = 32'(result_q[WIDTH-1:32]);
    end else begin : g_narrow
      always_comb begin
        base_nx = base_q;
        if (wr_base) base_nx = avs_writedata[WIDTH-1:0];
      end
      assign base_lo_rd = 32'(base_q);
      assign res_lo_rd  = 32'(result_q);
      assign base_hi_rd = '0;
      assign res_hi_rd  = '0;
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      3'd0:    rd_mux = {30'b0, irq_en, busy};
      3'd1:    rd_mux = base_lo_rd;
      3'd2:    rd_mux = 32'(exp_q);
      3'd3:    rd_mux = res_lo_rd;
      3'd4:    rd_mux = {29'b0, ovf, done, busy};
      3'd5:    rd_mux = base_hi_rd;
      3'd6:    rd_mux = res_hi_rd;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      base_q       <= '0;
      exp_q        <= '0;
      irq_en       <= 1'b0;
      avs_readdata <= '0;
    end else begin
      base_q <= base_nx;
      if (wr_exp) exp_q <= avs_writedata[EXP_WIDTH-1:0];
      if (wr_ctrl) irq_en <= avs_writedata[1];
      // Mux sees pre-write values, so read-during-write returns old data.
      avs_readdata <= avs_read ? rd_mux : '0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= S_IDLE;
      acc      <= '0;
      b        <= '0;
      e        <= '0;
      result_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      // W1C first; engine updates below take priority.
      if (wr_status) begin
        if (avs_writedata[1]) done <= 1'b0;
        if (avs_writedata[2]) ovf  <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= WIDTH'(1);
            b     <= base_q;
            e     <= exp_q;
            done  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          state <= (e == '0) ? S_FINISH : S_MUL;
        end
        S_MUL: begin
          if (e[0]) begin
            acc <= prod_lo;
            if (prod_hi != '0) ovf <= 1'b1;
          end
          state <= S_SQR;
        end
        S_SQR: begin
          b <= prod_lo;
          e <= e >> 1;
          // A lost square only matters if it is used again.
          if ((prod_hi != '0) && ((e >> 1) != '0)) ovf <= 1'b1;
          state <= S_CHECK;
        end
        S_FINISH: begin
          result_q <= acc;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign irq         = done & irq_en;
  assign busy_export = busy;

endmodule
